// File: rtl/cache_pkg.sv
// Shared types and widths for the N-way write-back cache.
// The widths below describe the default configuration; modules derive their own from parameters.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB_REQ,
        S_REFILL_REQ,
        S_REFILL_WAIT
    } state_e;

    localparam int unsigned DEF_ADDR_WIDTH = 11;
    localparam int unsigned DEF_NUM_SETS   = 16;
    localparam int unsigned DEF_NUM_WAYS   = 4;

    localparam int unsigned IDX_W = $clog2(DEF_NUM_SETS);
    localparam int unsigned TAG_W = DEF_ADDR_WIDTH - IDX_W;
    localparam int unsigned LRU_W = $clog2(DEF_NUM_WAYS);

    // Index width that stays at least one bit wide for single-entry structures.
    function automatic int unsigned bits_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cache_lru_nway.sv
// True-LRU replacement state: per-set age counters, touch update and victim select.
module cache_lru_nway
    import cache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned NUM_WAYS = 4,
    localparam int unsigned SET_W   = $clog2(NUM_SETS),
    localparam int unsigned WAY_W   = bits_of(NUM_WAYS)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_touch,
    input  logic [SET_W-1:0] i_set,
    input  logic [WAY_W-1:0] i_way,
    output logic [WAY_W-1:0] o_victim
);

    if (NUM_WAYS == 1) begin : g_one
        assign o_victim = '0;
    end else begin : g_lru
        logic [WAY_W-1:0] r_age [NUM_SETS][NUM_WAYS];

        // Ages start as the way number so each set holds a permutation from reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < int'(NUM_SETS); s++) begin
                    for (int w = 0; w < int'(NUM_WAYS); w++) begin
                        r_age[s][w] <= WAY_W'(w);
                    end
                end
            end else if (i_touch) begin
                for (int w = 0; w < int'(NUM_WAYS); w++) begin
                    if (WAY_W'(w) == i_way) begin
                        r_age[i_set][w] <= '0;
                    end else if (r_age[i_set][w] < r_age[i_set][i_way]) begin
                        r_age[i_set][w] <= r_age[i_set][w] + WAY_W'(1);
                    end
                end
            end
        end

        always_comb begin
            o_victim = '0;
            for (int w = 0; w < int'(NUM_WAYS); w++) begin
                if (r_age[i_set][w] == WAY_W'(NUM_WAYS - 1)) begin
                    o_victim = WAY_W'(w);
                end
            end
        end
    end

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate cache, one word per line.
// Optional CACHE_STATS_EN adds saturating hit/miss/writeback counters.
module cache_nway_wb
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SETS   = 16,
    parameter int unsigned NUM_WAYS   = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  hit,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses,
    output logic [31:0]           stat_writebacks
`endif
);

    localparam int unsigned SET_W    = $clog2(NUM_SETS);
    localparam int unsigned TAG_BITS = ADDR_WIDTH - SET_W;
    localparam int unsigned WAY_W    = bits_of(NUM_WAYS);

    state_e                r_state, w_state_n;
    logic                  r_req_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [WAY_W-1:0]      r_vict_way, w_vict_way_n;

    logic                  r_req_ready, w_req_ready_n;
    logic                  r_resp_valid, w_resp_valid_n;
    logic                  r_hit, w_hit_n;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_n;
    logic                  r_mreq, w_mreq_n;
    logic                  r_mwrite, w_mwrite_n;
    logic [ADDR_WIDTH-1:0] r_maddr, w_maddr_n;
    logic [DATA_WIDTH-1:0] r_mwdata, w_mwdata_n;

    logic [TAG_BITS-1:0]   r_tag_mem  [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] r_data_mem [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   r_valid    [NUM_SETS];
    logic [NUM_WAYS-1:0]   r_dirty    [NUM_SETS];

    logic [SET_W-1:0]      w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_accept;
    logic                  w_hit;
    logic [WAY_W-1:0]      w_hit_way;
    logic                  w_inv_found;
    logic [WAY_W-1:0]      w_inv_way;
    logic [WAY_W-1:0]      w_lru_way;
    logic [WAY_W-1:0]      w_victim;
    logic                  w_wr_en;
    logic [WAY_W-1:0]      w_wr_way;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_wr_dirty;
    logic                  w_touch;
    logic [WAY_W-1:0]      w_touch_way;

    assign w_idx    = r_addr[SET_W-1:0];
    assign w_tag    = r_addr[ADDR_WIDTH-1:SET_W];
    assign w_accept = (r_state == S_IDLE) && req_valid;

    // Tag match and lowest-numbered free way in the addressed set.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (r_valid[w_idx][w] && (r_tag_mem[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
        end
    end

    assign w_victim = w_inv_found ? w_inv_way : w_lru_way;

    cache_lru_nway #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_lru (
        .clk      (clk),
        .rst      (rst),
        .i_touch  (w_touch),
        .i_set    (w_idx),
        .i_way    (w_touch_way),
        .o_victim (w_lru_way)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_hit        <= 1'b0;
            r_rdata      <= '0;
            r_mreq       <= 1'b0;
            r_mwrite     <= 1'b0;
            r_maddr      <= '0;
            r_mwdata     <= '0;
            r_vict_way   <= '0;
            r_req_write  <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_state_n;
            r_req_ready  <= w_req_ready_n;
            r_resp_valid <= w_resp_valid_n;
            r_hit        <= w_hit_n;
            r_rdata      <= w_rdata_n;
            r_mreq       <= w_mreq_n;
            r_mwrite     <= w_mwrite_n;
            r_maddr      <= w_maddr_n;
            r_mwdata     <= w_mwdata_n;
            r_vict_way   <= w_vict_way_n;
            if (w_accept) begin
                r_req_write <= req_write;
                r_addr      <= addr;
                r_wdata     <= wdata;
            end
        end
    end

    // Next state, next registered outputs and array write/touch strobes.
    always_comb begin
        w_state_n      = r_state;
        w_req_ready_n  = r_req_ready;
        w_resp_valid_n = 1'b0;
        w_hit_n        = r_hit;
        w_rdata_n      = r_rdata;
        w_mreq_n       = r_mreq;
        w_mwrite_n     = r_mwrite;
        w_maddr_n      = r_maddr;
        w_mwdata_n     = r_mwdata;
        w_vict_way_n   = r_vict_way;
        w_wr_en        = 1'b0;
        w_wr_way       = w_hit_way;
        w_wr_data      = r_wdata;
        w_wr_dirty     = 1'b0;
        w_touch        = 1'b0;
        w_touch_way    = w_hit_way;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_n     = S_LOOKUP;
                    w_req_ready_n = 1'b0;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    w_touch        = 1'b1;
                    w_resp_valid_n = 1'b1;
                    w_hit_n        = 1'b1;
                    w_req_ready_n  = 1'b1;
                    w_state_n      = S_IDLE;
                    if (r_req_write) begin
                        w_wr_en    = 1'b1;
                        w_wr_dirty = 1'b1;
                        w_rdata_n  = r_wdata;
                    end else begin
                        w_rdata_n  = r_data_mem[w_idx][w_hit_way];
                    end
                end else begin
                    w_vict_way_n = w_victim;
                    w_mreq_n     = 1'b1;
                    if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
                        w_state_n  = S_WB_REQ;
                        w_mwrite_n = 1'b1;
                        w_maddr_n  = {r_tag_mem[w_idx][w_victim], w_idx};
                        w_mwdata_n = r_data_mem[w_idx][w_victim];
                    end else begin
                        w_state_n  = S_REFILL_REQ;
                        w_mwrite_n = 1'b0;
                        w_maddr_n  = r_addr;
                    end
                end
            end
            S_WB_REQ: begin
                if (mem_req_ready) begin
                    w_state_n  = S_REFILL_REQ;
                    w_mwrite_n = 1'b0;
                    w_maddr_n  = r_addr;
                end
            end
            S_REFILL_REQ: begin
                // A response in this cycle predates acceptance and is dropped.
                if (mem_req_ready) begin
                    w_state_n = S_REFILL_WAIT;
                    w_mreq_n  = 1'b0;
                end
            end
            S_REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    w_wr_en        = 1'b1;
                    w_wr_way       = r_vict_way;
                    w_wr_data      = r_req_write ? r_wdata : mem_rdata;
                    w_wr_dirty     = r_req_write;
                    w_touch        = 1'b1;
                    w_touch_way    = r_vict_way;
                    w_resp_valid_n = 1'b1;
                    w_hit_n        = 1'b0;
                    w_rdata_n      = w_wr_data;
                    w_req_ready_n  = 1'b1;
                    w_state_n      = S_IDLE;
                end
            end
            default: begin
                w_state_n     = S_IDLE;
                w_req_ready_n = 1'b1;
                w_mreq_n      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_tag_mem[w_idx][w_wr_way]  <= w_tag;
            r_data_mem[w_idx][w_wr_way] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else if (w_wr_en) begin
            r_valid[w_idx][w_wr_way] <= 1'b1;
            r_dirty[w_idx][w_wr_way] <= w_wr_dirty;
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign hit           = r_hit;
    assign rdata         = r_rdata;
    assign mem_req_valid = r_mreq;
    assign mem_write     = r_mwrite;
    assign mem_addr      = r_maddr;
    assign mem_wdata     = r_mwdata;

`ifdef CACHE_STATS_EN
    logic [31:0] r_stat_hits, r_stat_misses, r_stat_wbs;
    logic        w_ev_hit, w_ev_miss, w_ev_wb;

    assign w_ev_hit  = (r_state == S_LOOKUP) && w_hit;
    assign w_ev_miss = (r_state == S_REFILL_WAIT) && mem_resp_valid;
    assign w_ev_wb   = (r_state == S_WB_REQ) && mem_req_ready;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
            r_stat_wbs    <= '0;
        end else begin
            if (w_ev_hit && (r_stat_hits != '1))    r_stat_hits   <= r_stat_hits + 32'd1;
            if (w_ev_miss && (r_stat_misses != '1)) r_stat_misses <= r_stat_misses + 32'd1;
            if (w_ev_wb && (r_stat_wbs != '1))      r_stat_wbs    <= r_stat_wbs + 32'd1;
        end
    end

    assign stat_hits       = r_stat_hits;
    assign stat_misses     = r_stat_misses;
    assign stat_writebacks = r_stat_wbs;
`endif

endmodule
